// File: rtl/mole_timer_pkg.sv
// Shared types and default sizes for the multi-hole mole countdown bank.
package mole_timer_pkg;

  // Per-channel lifecycle; encoding is fixed so the values can be probed in a debugger.
  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StCounting = 2'd1,
    StPending  = 2'd2
  } ch_state_e;

  localparam int unsigned DefaultNumHoles = 8;
  localparam int unsigned DefaultCntW     = 4;

endpackage

// File: rtl/mole_timer_channel.sv
// One hole's countdown: arms on start, decrements on tick, waits for its expiry to be reported.
module mole_timer_channel
  import mole_timer_pkg::*;
#(
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] start_value_i,
  input  logic             cancel_i,
  input  logic             report_i,
  output ch_state_e        state_o,
  output logic [CNT_W-1:0] count_o
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next state: cancel wins over everything, then start / tick / report by state.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (cancel_i && (state_q != StIdle)) begin
      state_d = StIdle;
      count_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (start_value_i != '0) begin
              state_d = StCounting;
              count_d = start_value_i;
            end else begin
              // Zero-length mole expires immediately without waiting for a tick.
              state_d = StPending;
              count_d = '0;
            end
          end
        end
        StCounting: begin
          if (tick_i) begin
            if (count_q == CNT_W'(1)) begin
              state_d = StPending;
              count_d = '0;
            end else begin
              count_d = count_q - 1'b1;
            end
          end
        end
        StPending: begin
          if (report_i) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          count_d = '0;
        end
      endcase
    end
  end

  // Channel state and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign state_o = state_q;
  assign count_o = count_q;

endmodule

// File: rtl/mole_timer_bank.sv
// Bank of per-hole countdown timers with a round-robin expiry reporter.
module mole_timer_bank
  import mole_timer_pkg::*;
#(
  parameter int unsigned NUM_HOLES = DefaultNumHoles,
  parameter int unsigned CNT_W     = DefaultCntW,
  localparam int unsigned IDX_W    = $clog2(NUM_HOLES)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       tick,
  input  logic                       start_valid,
  input  logic [IDX_W-1:0]           start_idx,
  input  logic [CNT_W-1:0]           start_value,
  output logic                       start_ready,
  input  logic [NUM_HOLES-1:0]       cancel_mask,
  output logic                       expired_valid,
  output logic [IDX_W-1:0]           expired_idx,
  input  logic                       expired_ready,
  output logic [NUM_HOLES-1:0]       active,
  output logic [NUM_HOLES*CNT_W-1:0] count_flat
);

  ch_state_e        ch_state [NUM_HOLES];
  logic [CNT_W-1:0] ch_count [NUM_HOLES];
  logic [NUM_HOLES-1:0] pending;
  logic [NUM_HOLES-1:0] ch_start;
  logic [NUM_HOLES-1:0] ch_report;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             hold_q, hold_d;
  logic [IDX_W-1:0] hold_idx_q, hold_idx_d;
  logic             scan_found;
  logic [IDX_W-1:0] scan_idx;
  logic             report_hs;

  for (genvar i = 0; i < NUM_HOLES; i++) begin : g_ch
    mole_timer_channel #(
      .CNT_W(CNT_W)
    ) u_channel (
      .clk          (clk),
      .reset_n      (reset_n),
      .tick_i       (tick),
      .start_i      (ch_start[i]),
      .start_value_i(start_value),
      .cancel_i     (cancel_mask[i]),
      .report_i     (ch_report[i]),
      .state_o      (ch_state[i]),
      .count_o      (ch_count[i])
    );

    assign pending[i] = (ch_state[i] == StPending);
    assign active[i]  = (ch_state[i] != StIdle);
    assign count_flat[i*CNT_W +: CNT_W] = ch_count[i];
  end

  // Start acceptance: decoded compare avoids indexing past NUM_HOLES for odd sizes.
  always_comb begin
    start_ready = 1'b0;
    ch_start    = '0;
    for (int unsigned i = 0; i < NUM_HOLES; i++) begin
      if ((start_idx == IDX_W'(i)) && (ch_state[i] == StIdle)) begin
        start_ready = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_HOLES; i++) begin
      ch_start[i] = start_valid && start_ready && (start_idx == IDX_W'(i));
    end
  end

  // Round-robin scan: first pending channel at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned j;
    j          = 0;
    scan_found = 1'b0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < NUM_HOLES; k++) begin
      j = (32'(rr_ptr_q) + k) % NUM_HOLES;
      if (!scan_found && pending[j]) begin
        scan_found = 1'b1;
        scan_idx   = IDX_W'(j);
      end
    end
  end

  // Report selection: keep offering a stalled report unless its channel stopped pending.
  always_comb begin
    if (hold_q && pending[hold_idx_q]) begin
      expired_valid = 1'b1;
      expired_idx   = hold_idx_q;
    end else begin
      expired_valid = scan_found;
      expired_idx   = scan_found ? scan_idx : '0;
    end
    // A cancel on the reported channel voids the handshake.
    report_hs = expired_valid && expired_ready && !cancel_mask[expired_idx];
    for (int unsigned i = 0; i < NUM_HOLES; i++) begin
      ch_report[i] = report_hs && (expired_idx == IDX_W'(i));
    end
    rr_ptr_d = rr_ptr_q;
    if (report_hs) begin
      rr_ptr_d = (expired_idx == IDX_W'(NUM_HOLES - 1)) ? '0 : expired_idx + 1'b1;
    end
    hold_d     = expired_valid && !expired_ready;
    hold_idx_d = expired_idx;
  end

  // Arbiter pointer and stall-hold registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q   <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
    end
  end

endmodule

// File: tb/tb_mole_timer_bank.sv
// Scoreboard bench for mole_timer_bank: directed scenarios plus random traffic vs. a behavioural model.
module tb_mole_timer_bank;

  localparam int N  = 8;
  localparam int W  = 4;
  localparam int IW = 3;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           tick = 1'b0;
  logic           start_valid = 1'b0;
  logic [IW-1:0]  start_idx = '0;
  logic [W-1:0]   start_value = '0;
  logic           start_ready;
  logic [N-1:0]   cancel_mask = '0;
  logic           expired_valid;
  logic [IW-1:0]  expired_idx;
  logic           expired_ready = 1'b0;
  logic [N-1:0]   active;
  logic [N*W-1:0] count_flat;

  mole_timer_bank #(
    .NUM_HOLES(N),
    .CNT_W    (W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .start_valid  (start_valid),
    .start_idx    (start_idx),
    .start_value  (start_value),
    .start_ready  (start_ready),
    .cancel_mask  (cancel_mask),
    .expired_valid(expired_valid),
    .expired_idx  (expired_idx),
    .expired_ready(expired_ready),
    .active       (active),
    .count_flat   (count_flat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int mon_e;

  // Reference model: state per hole (0 idle, 1 counting, 2 pending), remaining ticks,
  // round-robin start point and the report currently being stalled (-1 if none).
  int st[N];
  int rem[N];
  int rr;
  int held;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      st[i]  = 0;
      rem[i] = 0;
    end
    rr   = 0;
    held = -1;
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (rr + k) % N;
      if (st[j] == 2) return j;
    end
    return -1;
  endfunction

  // One clock cycle: drive inputs, compare outputs against the model, queue the expected report.
  task automatic step(input bit tk, input bit sv, input int si, input int sval,
                      input logic [N-1:0] cm, input bit rdy);
    int             sel;
    bit             esr;
    bit             hs;
    logic [N-1:0]   ea;
    logic [N*W-1:0] ec;
    @(negedge clk);
    tick          = tk;
    start_valid   = sv;
    start_idx     = 3'(si);
    start_value   = 4'(sval);
    cancel_mask   = cm;
    expired_ready = rdy;
    #1;
    sel = (held >= 0 && st[held] == 2) ? held : pick();
    esr = (st[si] == 0);
    for (int i = 0; i < N; i++) begin
      ea[i]          = (st[i] != 0);
      ec[i*W +: W]   = 4'(rem[i]);
    end
    chk("active", 64'(active), 64'(ea));
    chk("count_flat", 64'(count_flat), 64'(ec));
    chk("start_ready", 64'(start_ready), 64'(esr));
    chk("expired_valid", 64'(expired_valid), 64'(sel >= 0));
    if (sel >= 0) chk("expired_idx", 64'(expired_idx), 64'(sel));
    hs = (sel >= 0) && rdy && !cm[sel];
    if (hs) exp_q.push_back(sel);
    for (int i = 0; i < N; i++) begin
      if (cm[i] && st[i] != 0) begin
        st[i]  = 0;
        rem[i] = 0;
      end else if (st[i] == 0) begin
        if (sv && esr && si == i) begin
          if (sval != 0) begin
            st[i]  = 1;
            rem[i] = sval;
          end else begin
            st[i] = 2;
          end
        end
      end else if (st[i] == 1) begin
        if (tk) begin
          rem[i] = rem[i] - 1;
          if (rem[i] == 0) st[i] = 2;
        end
      end else if (hs && sel == i) begin
        st[i] = 0;
      end
    end
    if (hs) rr = (sel + 1) % N;
    held = (sel >= 0 && !rdy) ? sel : -1;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0, 0, '0, 1'b0);
  endtask

  // Asynchronous reset taken between clock edges; state must vanish immediately.
  task automatic do_reset();
    @(negedge clk);
    tick = 1'b0; start_valid = 1'b0; cancel_mask = '0; expired_ready = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk("rst_active", 64'(active), 64'd0);
    chk("rst_count_flat", 64'(count_flat), 64'd0);
    chk("rst_expired_valid", 64'(expired_valid), 64'd0);
    chk("rst_expired_idx", 64'(expired_idx), 64'd0);
    chk("rst_queue_empty", 64'(exp_q.size()), 64'd0);
    model_reset();
    @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Monitor: every accepted report must match the oldest expected report.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && expired_valid && expired_ready && !cancel_mask[expired_idx]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: got report idx %0d, required no report", expired_idx);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_report_idx", 64'(expired_idx), 64'(mon_e));
        end
      end
    end
  end

  initial begin
    model_reset();
    #1;
    chk("init_active", 64'(active), 64'd0);
    chk("init_count_flat", 64'(count_flat), 64'd0);
    chk("init_expired_valid", 64'(expired_valid), 64'd0);
    chk("init_expired_idx", 64'(expired_idx), 64'd0);
    chk("init_start_ready", 64'(start_ready), 64'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Basic countdown on ch3.
    step(1'b0, 1'b1, 3, 2, '0, 1'b0);
    idle(9);
    step(1'b1, 1'b0, 0, 0, '0, 1'b0);
    idle(9);
    step(1'b1, 1'b0, 0, 0, '0, 1'b0);
    #1;
    chk("basic_valid", 64'(expired_valid), 64'd1);
    chk("basic_idx", 64'(expired_idx), 64'd3);
    step(1'b0, 1'b0, 0, 0, '0, 1'b1);
    #1;
    chk("basic_active_clear", 64'(active), 64'd0);

    // Zero-length start expires with no tick.
    step(1'b0, 1'b1, 5, 0, '0, 1'b0);
    #1;
    chk("zero_valid", 64'(expired_valid), 64'd1);
    chk("zero_idx", 64'(expired_idx), 64'd5);
    step(1'b0, 1'b0, 0, 0, '0, 1'b1);

    // Busy channel refuses a second start.
    step(1'b0, 1'b1, 1, 4, '0, 1'b0);
    step(1'b0, 1'b1, 1, 9, '0, 1'b0);
    #1;
    chk("busy_count", 64'(count_flat[1*W +: W]), 64'd4);
    step(1'b0, 1'b0, 0, 0, 8'h02, 1'b0);

    // Cancel beats expiry on the same edge.
    step(1'b0, 1'b1, 2, 1, '0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 8'h04, 1'b0);
    #1;
    chk("cancel_valid", 64'(expired_valid), 64'd0);
    chk("cancel_active", 64'(active), 64'd0);

    // Fairness: simultaneous expiries reported in round-robin order.
    do_reset();
    step(1'b0, 1'b1, 0, 1, '0, 1'b1);
    step(1'b0, 1'b1, 4, 1, '0, 1'b1);
    step(1'b0, 1'b1, 7, 1, '0, 1'b1);
    step(1'b1, 1'b0, 0, 0, '0, 1'b1);
    #1 chk("fair_first", 64'(expired_idx), 64'd0);
    step(1'b0, 1'b0, 0, 0, '0, 1'b1);
    #1 chk("fair_second", 64'(expired_idx), 64'd4);
    step(1'b0, 1'b0, 0, 0, '0, 1'b1);
    #1 chk("fair_third", 64'(expired_idx), 64'd7);
    step(1'b0, 1'b0, 0, 0, '0, 1'b1);
    #1 chk("fair_drained", 64'(expired_valid), 64'd0);
    step(1'b0, 1'b1, 4, 1, '0, 1'b1);
    step(1'b0, 1'b1, 0, 1, '0, 1'b1);
    step(1'b1, 1'b0, 0, 0, '0, 1'b1);
    #1 chk("refair_first", 64'(expired_idx), 64'd0);
    step(1'b0, 1'b0, 0, 0, '0, 1'b1);
    #1 chk("refair_second", 64'(expired_idx), 64'd4);
    step(1'b0, 1'b0, 0, 0, '0, 1'b1);

    // Back-pressure: a stalled report stays put even when a lower channel expires.
    do_reset();
    step(1'b0, 1'b1, 6, 1, '0, 1'b0);
    step(1'b0, 1'b1, 5, 2, '0, 1'b0);
    step(1'b1, 1'b0, 0, 0, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(k == 0, 1'b0, 0, 0, '0, 1'b0);
      #1 chk("bp_idx_stable", 64'(expired_idx), 64'd6);
    end
    step(1'b0, 1'b0, 0, 0, '0, 1'b1);
    #1 chk("bp_next", 64'(expired_idx), 64'd5);
    step(1'b0, 1'b0, 0, 0, '0, 1'b1);

    // Random traffic.
    for (int r = 0; r < 1500; r++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 15)), 8'($urandom & $urandom & $urandom & $urandom),
           $urandom_range(0, 1) == 1);
    end

    // Reset mid-count discards everything; nothing is reported afterwards.
    do_reset();
    step(1'b0, 1'b1, 2, 9, '0, 1'b1);
    step(1'b0, 1'b1, 6, 3, '0, 1'b1);
    step(1'b1, 1'b0, 0, 0, '0, 1'b1);
    do_reset();
    repeat (6) step(1'b1, 1'b0, 0, 0, '0, 1'b1);
    #1 chk("post_reset_valid", 64'(expired_valid), 64'd0);

    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
